// File: rtl/sram_unified_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sram_unified_buffer
// Description : Single-port synchronous SRAM feeding the systolic array, with a
//               registered read port and a shared read/write address.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_unified_buffer #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write_enable,
    input  logic [ADDRESSSIZE-1:0] address,
    input  logic [WORDSIZE-1:0]    data_in,
    output logic [WORDSIZE-1:0]    data_out
);

    localparam int c_DEPTH = 2 ** ADDRESSSIZE;

    logic [WORDSIZE-1:0] r_mem [0:c_DEPTH-1];

    // The array has no reset; rst_n only gates writes so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (rst_n && write_enable) begin
            r_mem[address] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (!write_enable) begin
            data_out <= r_mem[address];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_unified_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_unified_buffer
// Description : Scoreboard bench for sram_unified_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_unified_buffer;

    localparam int ADDRESSSIZE = 10;
    localparam int WORDSIZE    = 64;
    localparam int DEPTH       = 2 ** ADDRESSSIZE;

    logic                   clk;
    logic                   rst_n;
    logic                   write_enable;
    logic [ADDRESSSIZE-1:0] address;
    logic [WORDSIZE-1:0]    data_in;
    logic [WORDSIZE-1:0]    data_out;

    logic [WORDSIZE-1:0] model [0:DEPTH-1];
    logic [WORDSIZE-1:0] sb_q [$];
    int errors = 0;
    int checks = 0;

    sram_unified_buffer #(
        .ADDRESSSIZE(ADDRESSSIZE),
        .WORDSIZE   (WORDSIZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_enable(write_enable),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Drives one operation, waits for the edge that samples it, then settles.
    task automatic cycle(input logic we, input int addr, input logic [WORDSIZE-1:0] din);
        write_enable = we;
        address      = addr[ADDRESSSIZE-1:0];
        data_in      = din;
        if (we) model[addr] = din;
        else    sb_q.push_back(model[addr]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [WORDSIZE-1:0] exp;
        exp = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL reset_async: data_out=%h required %h", data_out, exp);
        end
        write_enable = 1'b0;
        address      = '0;
        data_in      = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL reset_hold: data_out=%h required %h", data_out, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL reset_release: data_out=%h required %h", data_out, exp);
        end
    endtask

    task automatic test_fill_readback();
        logic [WORDSIZE-1:0] exp;
        for (int i = 0; i < 16; i++)
            cycle(1'b1, i, 64'h0001020304050607 + 64'(i) * 64'h0808080808080808);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, i, '0);
            exp = sb_q.pop_front();
            checks++;
            if (data_out !== exp) begin
                errors++;
                $display("FAIL fill_readback[%0d]: data_out=%h required %h", i, data_out, exp);
            end
        end
    endtask

    task automatic test_boundaries();
        int addrs [4];
        logic [WORDSIZE-1:0] exp;
        addrs = '{1023, 0, 1, 1022};
        cycle(1'b1, 1022, 64'hA5A5_5A5A_1234_5678);
        cycle(1'b1, 1023, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b1, 0,    64'h0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, addrs[k], '0);
            exp = sb_q.pop_front();
            checks++;
            if (data_out !== exp) begin
                errors++;
                $display("FAIL boundary[addr %0d]: data_out=%h required %h", addrs[k], data_out, exp);
            end
        end
    endtask

    task automatic test_write_hold();
        logic [WORDSIZE-1:0] val_a;
        logic [WORDSIZE-1:0] exp;
        cycle(1'b0, 5, '0);
        val_a = sb_q.pop_front();
        checks++;
        if (data_out !== val_a) begin
            errors++;
            $display("FAIL hold_read_a: data_out=%h required %h", data_out, val_a);
        end
        cycle(1'b1, 5, 64'hB0B1_B2B3_B4B5_B6B7);
        checks++;
        if (data_out !== val_a) begin
            errors++;
            $display("FAIL hold_during_write: data_out=%h required %h", data_out, val_a);
        end
        cycle(1'b0, 5, '0);
        exp = sb_q.pop_front();
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL raw_read_b: data_out=%h required %h", data_out, exp);
        end
    endtask

    task automatic test_reset_midstream();
        logic [WORDSIZE-1:0] exp;
        logic [WORDSIZE-1:0] zero;
        zero = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, i, '0);
            exp = sb_q.pop_front();
            checks++;
            if (data_out !== exp) begin
                errors++;
                $display("FAIL midstream_pre[%0d]: data_out=%h required %h", i, data_out, exp);
            end
        end
        // Pulse reset between edges; the model is not updated for the blocked write.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== zero) begin
            errors++;
            $display("FAIL midstream_async: data_out=%h required %h", data_out, zero);
        end
        write_enable = 1'b1;
        address      = 10'd2;
        data_in      = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== zero) begin
            errors++;
            $display("FAIL midstream_hold: data_out=%h required %h", data_out, zero);
        end
        @(negedge clk);
        write_enable = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, i, '0);
            exp = sb_q.pop_front();
            checks++;
            if (data_out !== exp) begin
                errors++;
                $display("FAIL midstream_post[%0d]: data_out=%h required %h", i, data_out, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WORDSIZE-1:0] exp;
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 100 + i, {$urandom(), $urandom()});
        for (int i = 7; i >= 0; i--) begin
            cycle(1'b0, 100 + i, '0);
            exp = sb_q.pop_front();
            checks++;
            if (data_out !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: data_out=%h required %h", 100 + i, data_out, exp);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        write_enable = 1'b0;
        address      = '0;
        data_in      = '0;
        test_reset();
        test_fill_readback();
        test_boundaries();
        test_write_hold();
        test_reset_midstream();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
